// File: rtl/str_pkg.sv
// Shared types and width helpers for the stream alignment blocks.
package str_pkg;

    localparam int unsigned STR_DATA_WIDTH = 512;
    localparam int unsigned STR_BYTE_WIDTH = 8;
    localparam int unsigned STR_LEN_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } str_state_e;

    // Number of bits needed to hold the value x (at least 1).
    function automatic int unsigned log2(input int unsigned x);
        int unsigned bits;
        bits = 1;
        for (int i = 1; i < 32; i++) begin
            if ((x >> i) != 0) bits = i + 1;
        end
        return bits;
    endfunction

    localparam int unsigned STR_BYTE_CNT   = STR_DATA_WIDTH / STR_BYTE_WIDTH;
    localparam int unsigned STR_OFS_WIDTH  = log2(STR_BYTE_CNT - 1);
    localparam int unsigned STR_FILL_WIDTH = log2(2 * STR_BYTE_CNT - 1);

endpackage

// File: rtl/str_byte_sft.sv
// Byte-lane shifter: moves data and keep left or right by i_sft lanes.
module str_byte_sft
#(
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned IN_LANES   = 8,
    parameter int unsigned OUT_LANES  = 15,
    parameter int unsigned SFT_WIDTH  = 4,
    parameter bit          LEFT       = 1'b1
) (
    input  logic [IN_LANES*BYTE_WIDTH-1:0]  i_data,
    input  logic [IN_LANES-1:0]             i_keep,
    input  logic [SFT_WIDTH-1:0]            i_sft,
    output logic [OUT_LANES*BYTE_WIDTH-1:0] o_data,
    output logic [OUT_LANES-1:0]            o_keep
);

    localparam int unsigned TOT_LANES = (IN_LANES > OUT_LANES) ? IN_LANES : OUT_LANES;
    localparam int unsigned TOT_WIDTH = TOT_LANES * BYTE_WIDTH;

    logic [TOT_WIDTH-1:0] ext_data;
    logic [TOT_WIDTH-1:0] sft_data;
    logic [TOT_LANES-1:0] ext_keep;
    logic [TOT_LANES-1:0] sft_keep;

    always_comb begin
        ext_data = TOT_WIDTH'(i_data);
        ext_keep = TOT_LANES'(i_keep);
    end

    if (LEFT) begin : g_left
        assign sft_data = ext_data << (32'(i_sft) * BYTE_WIDTH);
        assign sft_keep = ext_keep << i_sft;
    end else begin : g_right
        assign sft_data = ext_data >> (32'(i_sft) * BYTE_WIDTH);
        assign sft_keep = ext_keep >> i_sft;
    end

    assign o_data = sft_data[OUT_LANES*BYTE_WIDTH-1:0];
    assign o_keep = sft_keep[OUT_LANES-1:0];

endmodule

// File: rtl/str_ofs_extract.sv
// Drops bytes before the command offset and past its length, and re-packs the
// remaining bytes into a lane-0 aligned stream with tkeep/tlast.
module str_ofs_extract
    import str_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = STR_DATA_WIDTH,
    parameter  int unsigned BYTE_WIDTH = STR_BYTE_WIDTH,
    parameter  int unsigned LEN_WIDTH  = STR_LEN_WIDTH,
    localparam int unsigned BYTE_CNT   = DATA_WIDTH / BYTE_WIDTH,
    localparam int unsigned OFS_WIDTH  = log2(BYTE_CNT - 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_vld,
    output logic                  o_cmd_rdy,
    input  logic [OFS_WIDTH-1:0]  i_cmd_ofs,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvld,
    output logic                  s_axis_trdy,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [BYTE_CNT-1:0]   m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvld,
    input  logic                  m_axis_trdy
);

    localparam int unsigned NUM_WIDTH  = log2(BYTE_CNT);
    localparam int unsigned BUF_LANES  = 2 * BYTE_CNT - 1;
    localparam int unsigned BUF_WIDTH  = BUF_LANES * BYTE_WIDTH;
    localparam int unsigned FILL_WIDTH = log2(BUF_LANES);
    localparam int unsigned REM_WIDTH  = LEN_WIDTH + 1;

    str_state_e             state_q;
    logic [FILL_WIDTH-1:0]  fill_q;
    logic [BUF_WIDTH-1:0]   buf_q;
    logic [REM_WIDTH-1:0]   in_rem_q;
    logic [REM_WIDTH-1:0]   out_rem_q;
    logic [OFS_WIDTH-1:0]   tail_q;
    logic [OFS_WIDTH-1:0]   ofs_q;
    logic [OFS_WIDTH-1:0]   last_lane_q;
    logic                   first_q;
    logic                   tvld_q;
    logic                   tlast_q;
    logic [BYTE_CNT-1:0]    tkeep_q;
    logic                   cmd_rdy_q;

    logic                   pop;
    logic                   push;
    logic                   in_last;
    logic [OFS_WIDTH-1:0]   lane_lo;
    logic [OFS_WIDTH-1:0]   lane_hi;
    logic [NUM_WIDTH-1:0]   n_lanes;
    logic [DATA_WIDTH-1:0]  aligned;
    logic [BYTE_CNT-1:0]    in_keep;
    logic [FILL_WIDTH-1:0]  fill_pop;
    logic [FILL_WIDTH-1:0]  fill_n;
    logic [BUF_WIDTH-1:0]   buf_pop;
    logic [BUF_WIDTH-1:0]   buf_n;
    logic [BUF_WIDTH-1:0]   app_data;
    logic [BUF_LANES-1:0]   app_keep;
    logic [REM_WIDTH-1:0]   in_rem_n;
    logic [REM_WIDTH-1:0]   out_rem_n;
    logic                   tvld_n;
    logic                   tlast_n;
    logic [BYTE_CNT-1:0]    tkeep_n;
    logic [REM_WIDTH-1:0]   cmd_sum;

    // Handshakes; s_axis_trdy is the only path from m_axis_trdy.
    always_comb begin
        pop         = tvld_q & m_axis_trdy;
        s_axis_trdy = (state_q == RUN) & ((fill_q < FILL_WIDTH'(BYTE_CNT)) | pop);
        push        = s_axis_trdy & s_axis_tvld;
    end

    // Wanted lane window of the current input word, realigned to lane 0.
    always_comb begin
        in_last = (in_rem_q == REM_WIDTH'(1));
        lane_lo = first_q ? ofs_q : '0;
        lane_hi = in_last ? last_lane_q : OFS_WIDTH'(BYTE_CNT - 1);
        n_lanes = NUM_WIDTH'(lane_hi) - NUM_WIDTH'(lane_lo) + NUM_WIDTH'(1);
        aligned = s_axis_tdata >> (32'(lane_lo) * BYTE_WIDTH);
        in_keep = '0;
        for (int i = 0; i < int'(BYTE_CNT); i++) begin
            in_keep[i] = (NUM_WIDTH'(i) < n_lanes);
        end
    end

    // Pop first, then append at the post-pop fill position.
    always_comb begin
        if (pop) begin
            fill_pop = (fill_q >= FILL_WIDTH'(BYTE_CNT)) ? fill_q - FILL_WIDTH'(BYTE_CNT) : '0;
            buf_pop  = buf_q >> DATA_WIDTH;
        end else begin
            fill_pop = fill_q;
            buf_pop  = buf_q;
        end
        fill_n = fill_pop + (push ? FILL_WIDTH'(n_lanes) : '0);
    end

    str_byte_sft #(
        .BYTE_WIDTH (BYTE_WIDTH),
        .IN_LANES   (BYTE_CNT),
        .OUT_LANES  (BUF_LANES),
        .SFT_WIDTH  (FILL_WIDTH),
        .LEFT       (1'b1)
    ) u_append_sft (
        .i_data (aligned),
        .i_keep (in_keep),
        .i_sft  (fill_pop),
        .o_data (app_data),
        .o_keep (app_keep)
    );

    always_comb begin
        buf_n = buf_pop;
        for (int i = 0; i < int'(BUF_LANES); i++) begin
            if (push && app_keep[i]) buf_n[i*BYTE_WIDTH +: BYTE_WIDTH] = app_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Next output beat qualifiers.
    always_comb begin
        in_rem_n  = in_rem_q - REM_WIDTH'(push);
        out_rem_n = out_rem_q - REM_WIDTH'(pop);
        tvld_n    = (fill_n >= FILL_WIDTH'(BYTE_CNT)) |
                    ((in_rem_n == '0) & (fill_n != '0));
        tlast_n   = tvld_n & (out_rem_n == REM_WIDTH'(1));
        tkeep_n   = '0;
        for (int i = 0; i < int'(BYTE_CNT); i++) begin
            tkeep_n[i] = tvld_n & (~tlast_n | (tail_q == '0) | (OFS_WIDTH'(i) < tail_q));
        end
        cmd_sum = REM_WIDTH'(i_cmd_ofs) + REM_WIDTH'(i_cmd_len);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cmd_rdy_q   <= 1'b1;
            fill_q      <= '0;
            buf_q       <= '0;
            in_rem_q    <= '0;
            out_rem_q   <= '0;
            tail_q      <= '0;
            ofs_q       <= '0;
            last_lane_q <= '0;
            first_q     <= 1'b0;
            tvld_q      <= 1'b0;
            tlast_q     <= 1'b0;
            tkeep_q     <= '0;
        end else begin
            fill_q    <= fill_n;
            buf_q     <= buf_n;
            in_rem_q  <= in_rem_n;
            out_rem_q <= out_rem_n;
            tvld_q    <= tvld_n;
            tlast_q   <= tlast_n;
            tkeep_q   <= tkeep_n;
            if (push) first_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_cmd_vld) begin
                        in_rem_q    <= (cmd_sum + REM_WIDTH'(BYTE_CNT - 1)) / REM_WIDTH'(BYTE_CNT);
                        out_rem_q   <= (REM_WIDTH'(i_cmd_len) + REM_WIDTH'(BYTE_CNT - 1)) / REM_WIDTH'(BYTE_CNT);
                        tail_q      <= OFS_WIDTH'(REM_WIDTH'(i_cmd_len) % REM_WIDTH'(BYTE_CNT));
                        ofs_q       <= i_cmd_ofs;
                        last_lane_q <= OFS_WIDTH'((cmd_sum - REM_WIDTH'(1)) % REM_WIDTH'(BYTE_CNT));
                        first_q     <= 1'b1;
                        // Zero-length commands complete on acceptance.
                        if (i_cmd_len != '0) begin
                            state_q   <= RUN;
                            cmd_rdy_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (pop && tlast_q) begin
                        state_q   <= IDLE;
                        cmd_rdy_q <= 1'b1;
                    end else if (push && in_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && tlast_q) begin
                        state_q   <= IDLE;
                        cmd_rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cmd_rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_cmd_rdy    = cmd_rdy_q;
    assign m_axis_tdata = buf_q[DATA_WIDTH-1:0];
    assign m_axis_tkeep = tkeep_q;
    assign m_axis_tlast = tlast_q;
    assign m_axis_tvld  = tvld_q;

endmodule

// File: tb/tb_str_ofs_extract.sv
// Scoreboard bench for str_ofs_extract on a 64-bit bus; input byte = its index.
module tb_str_ofs_extract;

    localparam int unsigned DW = 64;
    localparam int unsigned BC = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [BC-1:0] keep;
        logic          last;
    } beat_t;

    logic          clk;
    logic          i_rst;
    logic          i_cmd_vld;
    logic          o_cmd_rdy;
    logic [2:0]    i_cmd_ofs;
    logic [15:0]   i_cmd_len;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvld;
    logic          s_axis_trdy;
    logic [DW-1:0] m_axis_tdata;
    logic [BC-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvld;
    logic          m_axis_trdy;

    beat_t exp_q[$];
    int    n_checks;
    int    n_errors;

    str_ofs_extract #(
        .DATA_WIDTH (DW),
        .BYTE_WIDTH (8),
        .LEN_WIDTH  (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_cmd_vld    (i_cmd_vld),
        .o_cmd_rdy    (o_cmd_rdy),
        .i_cmd_ofs    (i_cmd_ofs),
        .i_cmd_len    (i_cmd_len),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvld  (s_axis_tvld),
        .s_axis_trdy  (s_axis_trdy),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvld  (m_axis_tvld),
        .m_axis_trdy  (m_axis_trdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word(input int k);
        logic [DW-1:0] w;
        for (int j = 0; j < int'(BC); j++) w[j*8 +: 8] = 8'(k * 8 + j);
        return w;
    endfunction

    function automatic int wanted(input int k, input int ofs, input int len);
        int c;
        c = 0;
        for (int j = 0; j < int'(BC); j++) begin
            if ((k * 8 + j) >= ofs && (k * 8 + j) < ofs + len) c++;
        end
        return c;
    endfunction

    task automatic push_expected(input int ofs, input int len);
        int    n_out;
        int    cnt;
        beat_t b;
        n_out = (len + 7) / 8;
        for (int i = 0; i < n_out; i++) begin
            cnt    = (len - 8 * i < 8) ? len - 8 * i : 8;
            b.data = '0;
            b.keep = '0;
            for (int j = 0; j < cnt; j++) begin
                b.data[j*8 +: 8] = 8'(ofs + 8 * i + j);
                b.keep[j]        = 1'b1;
            end
            b.last = (i == n_out - 1);
            exp_q.push_back(b);
        end
    endtask

    // Issue one command, feed its words and score outputs; stop_after>0 aborts early.
    task automatic run_cmd(input int ofs, input int len, input bit rnd, input int stop_after);
        int            n_in;
        int            in_idx;
        int            fill;
        int            cyc;
        bit            in_hs;
        bit            out_hs;
        beat_t         e;
        logic [DW-1:0] mask;
        n_in = (len == 0) ? 0 : (ofs + len + 7) / 8;
        push_expected(ofs, len);
        @(negedge clk);
        i_cmd_vld = 1'b1;
        i_cmd_ofs = 3'(ofs);
        i_cmd_len = 16'(len);
        #1;
        check("cmd_rdy_before", {63'b0, o_cmd_rdy}, 64'd1);
        @(negedge clk);
        i_cmd_vld = 1'b0;
        in_idx = 0;
        fill   = 0;
        cyc    = 0;
        while ((exp_q.size() != 0 || in_idx < n_in) && cyc < 2000 &&
               (stop_after == 0 || cyc < stop_after)) begin
            s_axis_tvld  = (in_idx < n_in) && (!rnd || $urandom_range(0, 3) != 0);
            s_axis_tdata = word(in_idx);
            m_axis_trdy  = !rnd || $urandom_range(0, 2) != 0;
            #1;
            out_hs = m_axis_tvld & m_axis_trdy;
            in_hs  = s_axis_tvld & s_axis_trdy;
            if (cyc == 0) check("first_trdy", {63'b0, s_axis_trdy}, 64'd1);
            if (in_idx >= n_in) check("trdy_after_last", {63'b0, s_axis_trdy}, 64'd0);
            if (fill >= 8 && !out_hs) check("trdy_backpressure", {63'b0, s_axis_trdy}, 64'd0);
            if (out_hs) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", {63'b0, m_axis_tvld}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    mask = '0;
                    for (int j = 0; j < int'(BC); j++) if (e.keep[j]) mask[j*8 +: 8] = 8'hFF;
                    check("tdata", m_axis_tdata & mask, e.data);
                    check("tkeep", {56'b0, m_axis_tkeep}, {56'b0, e.keep});
                    check("tlast", {63'b0, m_axis_tlast}, {63'b0, e.last});
                    fill = fill - $countones(e.keep);
                end
            end
            if (in_hs) begin
                fill = fill + wanted(in_idx, ofs, len);
                in_idx++;
            end
            @(negedge clk);
            cyc++;
        end
        s_axis_tvld = 1'b0;
        if (stop_after == 0) begin
            #1;
            check("out_queue_empty", 64'(exp_q.size()), 64'd0);
            check("in_beats", 64'(in_idx), 64'(n_in));
            check("cmd_rdy_after", {63'b0, o_cmd_rdy}, 64'd1);
            if (len == 0) begin
                check("len0_tvld", {63'b0, m_axis_tvld}, 64'd0);
                check("len0_trdy", {63'b0, s_axis_trdy}, 64'd0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_rdy"}, {63'b0, o_cmd_rdy}, 64'd1);
        check({tag, "_tvld"},    {63'b0, m_axis_tvld}, 64'd0);
        check({tag, "_tlast"},   {63'b0, m_axis_tlast}, 64'd0);
        check({tag, "_tkeep"},   {56'b0, m_axis_tkeep}, 64'd0);
        check({tag, "_tdata"},   m_axis_tdata, 64'd0);
        check({tag, "_s_trdy"},  {63'b0, s_axis_trdy}, 64'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        i_rst        = 1'b1;
        i_cmd_vld    = 1'b0;
        i_cmd_ofs    = '0;
        i_cmd_len    = '0;
        s_axis_tdata = '0;
        s_axis_tvld  = 1'b0;
        m_axis_trdy  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        i_rst = 1'b0;

        run_cmd(0, 16, 1'b0, 0);
        run_cmd(3, 5, 1'b0, 0);
        run_cmd(5, 12, 1'b0, 0);
        run_cmd(7, 100, 1'b1, 0);
        run_cmd(0, 0, 1'b0, 0);
        run_cmd(2, 3, 1'b0, 0);

        // Abandon a command mid-flight with a reset.
        run_cmd(1, 40, 1'b0, 4);
        i_rst       = 1'b1;
        m_axis_trdy = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("mid_reset");
        i_rst = 1'b0;
        exp_q.delete();
        run_cmd(0, 8, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/str_ofs_extract.md
# str_ofs_extract

Read-side alignment block for the DMA data path. Memory reads return full bus words starting at the aligned address. Per command (start byte offset, byte length), this block consumes exactly the words that cover the requested range and drops leading bytes before the offset and trailing bytes past the length. It re-packs the remaining bytes into an AXI-Stream whose first byte is at lane 0, with correct tkeep and tlast. It sits between the memory read-data return and the downstream stream consumer.

## Interface
- DATA_WIDTH, 512, bus width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, lane width in bits.
- LEN_WIDTH, 16, width of the command byte length.
- Derived: BYTE_CNT = DATA_WIDTH/BYTE_WIDTH; OFS_WIDTH = log2(BYTE_CNT-1).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_cmd_vld  in  1  command valid.
- o_cmd_rdy  out  1  command ready; high only in IDLE.
- i_cmd_ofs  in  OFS_WIDTH  byte offset of the first wanted byte within the first input word.
- i_cmd_len  in  LEN_WIDTH  number of wanted bytes.
- s_axis_tdata  in  DATA_WIDTH  read data; all lanes are treated as present (no input keep/last).
- s_axis_tvld  in  1  input valid.
- s_axis_trdy  out  1  input ready.
- m_axis_tdata  out  DATA_WIDTH  packed data.
- m_axis_tkeep  out  BYTE_CNT  lane keep; contiguous from lane 0.
- m_axis_tlast  out  1  last beat of the command.
- m_axis_tvld  out  1  output valid.
- m_axis_trdy  in  1  output ready.

## Operation
- Command accept: i_cmd_vld & o_cmd_rdy. The block latches:
  - in_rem = ceil((ofs+len)/BYTE_CNT), computed in LEN_WIDTH+1 bits.
  - out_rem = ceil(len/BYTE_CNT).
  - tail = len mod BYTE_CNT.
  - ofs.
- Command with len = 0: accepted, state stays IDLE, no input or output beats.
- FSM states:
  - IDLE → RUN on accept with len ≠ 0.
  - RUN → DRAIN when the input beat that brings in_rem to 0 is accepted.
  - DRAIN → IDLE when the output beat with tlast is accepted.
  - RUN → IDLE directly when the final input and final output handshakes land in the same cycle.
- Holding buffer: 2·BYTE_CNT−1 byte lanes plus fill count (0..2·BYTE_CNT−1).
- Input beat handling:
  - First input beat: lanes ofs..BYTE_CNT−1 are written at buffer positions fill.. onward.
  - Later beats: all lanes are appended at position fill.
  - Final input beat: only lanes up to the last wanted byte are appended; excess lanes are discarded.
- An output beat pops BYTE_CNT lanes, shifting the buffer down by BYTE_CNT. If the same cycle also accepts input, the pop is applied first and the append second.
- m_axis_tvld (registered) is set when next-fill ≥ BYTE_CNT, or when in_rem = 0 and next-fill > 0.
- m_axis_tkeep:
  - all ones, except on the tlast beat;
  - on the tlast beat: low `tail` bits set, or all ones if tail = 0.
- m_axis_tlast = (out_rem = 1) while tvld is high. out_rem decrements on each output handshake.
- s_axis_trdy = (state = RUN) & (fill < BYTE_CNT | (m_axis_tvld & m_axis_trdy)). This is the only combinational path from m_axis_trdy.
- Reset (any time, including mid-command):
  - state = IDLE, o_cmd_rdy = 1.
  - fill, in_rem and out_rem = 0.
  - m_axis_tvld, m_axis_tlast and s_axis_trdy = 0.
  - m_axis_tkeep and m_axis_tdata = 0.
  - The partial command is abandoned.

## Timing
- Command to first s_axis_trdy: 1 cycle (registered state).
- Input-to-output latency: 1 cycle. An output beat is valid the cycle after the input handshake that satisfies the tvld condition.
- Steady state with both sides ready: 1 beat/cycle in and out; no bubbles.
- The last output beat may trail the last input beat by 1 cycle: a DRAIN beat exists iff N_out > number of outputs already issued.
- o_cmd_rdy rises the cycle after the tlast handshake. Back-to-back commands have a 1-cycle gap.
- tdata, tkeep and tlast are stable while tvld & !trdy.

## Structure
- Shared package str_pkg:
  - log2 function;
  - FSM state enum (IDLE, RUN, DRAIN);
  - derived-width constants (BYTE_CNT, OFS_WIDTH, fill width = log2(2·BYTE_CNT−1)).
- Sub-module str_byte_sft: parameterised byte-lane shifter (left or right by N lanes, with keep mask). It is instanced once for the append path.
- FSM, counters and buffer live in the top module.

## Test plan
Bench uses DATA_WIDTH = 64, BYTE_CNT = 8, input byte value = its global index.
- ofs=0, len=16: 2 in, 2 out; tkeep 0xFF, 0xFF; tlast on beat 2; data = bytes 0..15.
- ofs=3, len=5: 1 in, 1 out; lanes 0..4 = bytes 3..7; tkeep 0x1F; tlast = 1.
- ofs=5, len=12: 3 in, 2 out.
  - Beat 1 = bytes 5..12.
  - Beat 2 = bytes 13..16 with tkeep 0x0F and tlast.
  - No third s_axis_trdy after in_rem = 0.
- ofs=7, len=100, random m_axis_trdy and s_axis_tvld:
  - Output stream = bytes 7..106 exactly, 13 beats, final tkeep 0x0F.
  - s_axis_trdy = 0 whenever fill ≥ 8 and no pop.
- len=0 then ofs=2, len=3:
  - First command: no beats, o_cmd_rdy back in 1 cycle.
  - Second command: single beat, tkeep 0x07.
- i_rst asserted mid-RUN of ofs=1, len=40:
  - Next cycle: outputs at reset values, o_cmd_rdy = 1.
  - A new ofs=0, len=8 command completes correctly.
